dmc: RTL and testbench
======================

DMC -- requirements
Module: dmc

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8: data width in bits.
REQ-002 The block SHALL have parameter ADDR_W, default 8: address width; each bank depth is 2**ADDR_W (256 words).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port mem_select, input, 1 bit: bank select, 0 = bank A, 1 = bank B.
REQ-006 The block SHALL have port write_enable, input, 1 bit: 1 = write cycle, 0 = read cycle.
REQ-007 The block SHALL have port data_ex, input, DATA_W bits: write data.
REQ-008 The block SHALL have port add_ex, input, ADDR_W bits: word address within the selected bank.
REQ-009 The block SHALL have port data_out, output, DATA_W bits: registered read data.

Function
REQ-010 The block SHALL contain two independent banks, A and B, each holding 2**ADDR_W words of DATA_W bits.
REQ-011 On a rising edge with rst=0 and write_enable=1, the block SHALL store data_ex at add_ex in the selected bank only; the other bank SHALL be unchanged.
REQ-012 On a rising edge with rst=0 and write_enable=0, the block SHALL load data_out from the selected bank at add_ex (one-cycle read latency); no bank SHALL be modified.
REQ-013 During a write cycle, data_out SHALL hold its previous value (unless DMC_WRITE_THROUGH_EN is defined, see REQ-019).
REQ-014 A read of an address in the same cycle as its write is impossible, since one port serves both; a read in the cycle after a write SHALL return the newly written data.
REQ-015 The block SHALL decode the full address range 0x00..0xFF with no wrap or aliasing; mem_select and add_ex SHALL be sampled only at the clock edge.

Reset
REQ-016 When rst=1 at a rising edge, data_out SHALL become 0 and all words of both banks SHALL become 0.
REQ-017 rst SHALL take priority over write_enable; a write coinciding with reset SHALL be discarded.
REQ-018 After reset deasserts, the next edge SHALL perform normal operation; reset mid-sequence SHALL lose all previously written data.

Configuration
REQ-019 With macro DMC_WRITE_THROUGH_EN defined, a write cycle SHALL also load data_out with data_ex in the same edge; without it, REQ-013 SHALL apply.

Structure
REQ-020 A shared package dmc_pkg SHALL hold DATA_W/ADDR_W defaults and constants MEM_A=1'b0 and MEM_B=1'b1.
REQ-021 The block SHALL instantiate sub-module dmc_mem_bank (one synchronous write / registered read bank with sync clear) twice, once for A and once for B; a top-level mux SHALL select the read data.

Verification
REQ-022 The bench SHALL cover: reset, then write A[0x02]=0x0A, then read A[0x02] -> data_out=0x0A one edge after the read cycle.
REQ-023 The bench SHALL cover: write B[0x02]=0x0B, then read B[0x02] -> 0x0B; then read A[0x02] -> still 0x0A (bank isolation).
REQ-024 The bench SHALL cover: write A[0xFF]=0x5A and A[0x00]=0xA5, then read both -> 0x5A and 0xA5 (no aliasing at range ends).
REQ-025 The bench SHALL cover: during a write of 0x33 with data_out=0x0A -> data_out stays 0x0A without the macro, and becomes 0x33 with DMC_WRITE_THROUGH_EN.
REQ-026 The bench SHALL cover: rst=1 asserted simultaneously with a write of B[0x02]=0xFF, then read B[0x02] and A[0x02] -> both 0x00, and data_out=0x00 during reset.

Source files
------------

// File: rtl/dmc_pkg.sv
// Shared defaults and bank-select encodings for the dual-bank memory controller.
// Latency: n/a (constants only).
// Backpressure: n/a.
package dmc_pkg;

  localparam int DMC_DATA_W = 8;
  localparam int DMC_ADDR_W = 8;

  localparam logic MEM_A = 1'b0;
  localparam logic MEM_B = 1'b1;

endpackage

// File: rtl/dmc_mem_bank.sv
// One memory bank: synchronous write, registered read, synchronous clear of every word.
// Latency: read data appears on rdata one edge after a cycle with rd_en=1.
// Backpressure: none; an access is accepted every cycle.
module dmc_mem_bank #(
  parameter int DATA_W        = 8,
  parameter int ADDR_W        = 8,
  parameter bit WRITE_THROUGH = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  // One register per word so that reset can clear the whole bank in a single edge.
  for (genvar g = 0; g < DEPTH; g++) begin : g_word
    // Clear on reset, otherwise capture write data when this word is addressed.
    always_ff @(posedge clk) begin
      if (rst) begin
        mem[g] <= '0;
      end else if (we && (addr == ADDR_W'(g))) begin
        mem[g] <= wdata;
      end
    end
  end

  // Read register: loads on reads, optionally on writes, otherwise holds its value.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata <= '0;
    end else if (rd_en) begin
      rdata <= mem[addr];
    end else if (WRITE_THROUGH && we) begin
      rdata <= wdata;
    end
  end

endmodule

// File: rtl/dmc.sv
// Dual-bank memory controller: two independent banks (A/B) behind one shared read/write port.
// Latency: registered read, data_out valid one edge after the read cycle.
// Backpressure: none. Optional macro DMC_WRITE_THROUGH_EN makes a write also load data_out.
module dmc
  import dmc_pkg::*;
#(
  parameter int DATA_W = DMC_DATA_W,
  parameter int ADDR_W = DMC_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_select,
  input  logic              write_enable,
  input  logic [DATA_W-1:0] data_ex,
  input  logic [ADDR_W-1:0] add_ex,
  output logic [DATA_W-1:0] data_out
);

`ifdef DMC_WRITE_THROUGH_EN
  localparam bit WRITE_THROUGH = 1'b1;
`else
  localparam bit WRITE_THROUGH = 1'b0;
`endif

  logic              we_a;
  logic              we_b;
  logic              rd_a;
  logic              rd_b;
  logic [DATA_W-1:0] rdata_a;
  logic [DATA_W-1:0] rdata_b;
  logic              sel_q;

  // Steer the single access to exactly one bank.
  always_comb begin
    we_a = write_enable  && (mem_select == MEM_A);
    we_b = write_enable  && (mem_select == MEM_B);
    rd_a = !write_enable && (mem_select == MEM_A);
    rd_b = !write_enable && (mem_select == MEM_B);
  end

  dmc_mem_bank #(
    .DATA_W        (DATA_W),
    .ADDR_W        (ADDR_W),
    .WRITE_THROUGH (WRITE_THROUGH)
  ) u_bank_a (
    .clk   (clk),
    .rst   (rst),
    .we    (we_a),
    .rd_en (rd_a),
    .addr  (add_ex),
    .wdata (data_ex),
    .rdata (rdata_a)
  );

  dmc_mem_bank #(
    .DATA_W        (DATA_W),
    .ADDR_W        (ADDR_W),
    .WRITE_THROUGH (WRITE_THROUGH)
  ) u_bank_b (
    .clk   (clk),
    .rst   (rst),
    .we    (we_b),
    .rd_en (rd_b),
    .addr  (add_ex),
    .wdata (data_ex),
    .rdata (rdata_b)
  );

  // Remember which bank last loaded its read register; writes leave it alone
  // unless write-through is on, so data_out holds across a write.
  always_ff @(posedge clk) begin
    if (rst) begin
      sel_q <= MEM_A;
    end else if (!write_enable || WRITE_THROUGH) begin
      sel_q <= mem_select;
    end
  end

  // Output mux; both read registers clear on reset so data_out is 0 either way.
  always_comb begin
    data_out = (sel_q == MEM_B) ? rdata_b : rdata_a;
  end

endmodule

// File: tb/tb_dmc.sv
// Directed, table-driven bench for dmc.
// Latency: checks data_out 1 time unit after each rising edge.
// Backpressure: n/a.
module tb_dmc;

  logic       clk;
  logic       rst;
  logic       mem_select;
  logic       write_enable;
  logic [7:0] data_ex;
  logic [7:0] add_ex;
  logic [7:0] data_out;

  int checks;
  int failures;

`ifdef DMC_WRITE_THROUGH_EN
  localparam bit WT = 1'b1;
`else
  localparam bit WT = 1'b0;
`endif

  dmc #(.DATA_W(8), .ADDR_W(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .mem_select   (mem_select),
    .write_enable (write_enable),
    .data_ex      (data_ex),
    .add_ex       (add_ex),
    .data_out     (data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected data_out after the edge: exp without write-through, exp_wt with it.
  typedef struct {
    logic       rst;
    logic       sel;
    logic       we;
    logic [7:0] d;
    logic [7:0] a;
    logic [7:0] exp;
    logic [7:0] exp_wt;
  } vec_t;

  localparam int NV = 19;
  vec_t vt [NV];

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: data_out=0x%02h expected=0x%02h", name, act, exp);
    end
  endtask

  // Drive one cycle on the falling edge, let the rising edge act, sample 1 unit later.
  task automatic cyc(input logic r, input logic s, input logic w,
                     input logic [7:0] d, input logic [7:0] a);
    @(negedge clk);
    rst          = r;
    mem_select   = s;
    write_enable = w;
    data_ex      = d;
    add_ex       = a;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] e;
    checks   = 0;
    failures = 0;
    rst          = 1'b1;
    mem_select   = 1'b0;
    write_enable = 1'b0;
    data_ex      = 8'h00;
    add_ex       = 8'h00;

    //          rst  sel   we    data   addr   exp    exp_wt
    vt[0]  = '{1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00}; // reset
    vt[1]  = '{1'b0, 1'b0, 1'b1, 8'h0A, 8'h02, 8'h00, 8'h0A}; // write A[02]=0A
    vt[2]  = '{1'b0, 1'b0, 1'b0, 8'h00, 8'h02, 8'h0A, 8'h0A}; // read A[02]
    vt[3]  = '{1'b0, 1'b1, 1'b1, 8'h0B, 8'h02, 8'h0A, 8'h0B}; // write B[02]=0B
    vt[4]  = '{1'b0, 1'b1, 1'b0, 8'h00, 8'h02, 8'h0B, 8'h0B}; // read B[02]
    vt[5]  = '{1'b0, 1'b0, 1'b0, 8'h00, 8'h02, 8'h0A, 8'h0A}; // read A[02] isolation
    vt[6]  = '{1'b0, 1'b0, 1'b1, 8'h5A, 8'hFF, 8'h0A, 8'h5A}; // write A[FF]=5A
    vt[7]  = '{1'b0, 1'b0, 1'b1, 8'hA5, 8'h00, 8'h0A, 8'hA5}; // write A[00]=A5
    vt[8]  = '{1'b0, 1'b0, 1'b0, 8'h00, 8'hFF, 8'h5A, 8'h5A}; // read A[FF]
    vt[9]  = '{1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'hA5, 8'hA5}; // read A[00]
    vt[10] = '{1'b0, 1'b1, 1'b0, 8'h00, 8'hFF, 8'h00, 8'h00}; // read B[FF] untouched
    vt[11] = '{1'b0, 1'b0, 1'b0, 8'h00, 8'h02, 8'h0A, 8'h0A}; // read A[02]
    vt[12] = '{1'b0, 1'b0, 1'b1, 8'h33, 8'h10, 8'h0A, 8'h33}; // write 33 while out=0A
    vt[13] = '{1'b0, 1'b0, 1'b0, 8'h00, 8'h10, 8'h33, 8'h33}; // read A[10]
    vt[14] = '{1'b0, 1'b0, 1'b0, 8'h00, 8'h01, 8'h00, 8'h00}; // read A[01] unwritten
    vt[15] = '{1'b1, 1'b1, 1'b1, 8'hFF, 8'h02, 8'h00, 8'h00}; // reset + write B[02]=FF
    vt[16] = '{1'b0, 1'b1, 1'b0, 8'h00, 8'h02, 8'h00, 8'h00}; // read B[02] after reset
    vt[17] = '{1'b0, 1'b0, 1'b0, 8'h00, 8'h02, 8'h00, 8'h00}; // read A[02] after reset
    vt[18] = '{1'b0, 1'b0, 1'b0, 8'h00, 8'hFF, 8'h00, 8'h00}; // read A[FF] after reset

    for (int i = 0; i < NV; i++) begin
      cyc(vt[i].rst, vt[i].sel, vt[i].we, vt[i].d, vt[i].a);
      check($sformatf("vec%0d", i), data_out, WT ? vt[i].exp_wt : vt[i].exp);
    end

    // Inputs change between edges without a clock: data_out must not move.
    cyc(1'b0, 1'b0, 1'b1, 8'h77, 8'h40);               // write A[40]=77
    cyc(1'b0, 1'b0, 1'b0, 8'h00, 8'h40);               // read A[40]
    check("read_a40", data_out, 8'h77);
    @(negedge clk);
    mem_select = 1'b1;
    add_ex     = 8'h99;
    #2;
    check("no_edge_hold", data_out, 8'h77);

    // Fill both banks across the full range, then read back: no aliasing anywhere.
    for (int i = 0; i < 256; i++) begin
      cyc(1'b0, 1'b0, 1'b1, 8'(i) ^ 8'h5C, 8'(i));
      cyc(1'b0, 1'b1, 1'b1, ~8'(i), 8'(i));
    end
    for (int i = 0; i < 256; i++) begin
      cyc(1'b0, 1'b0, 1'b0, 8'h00, 8'(i));
      e = 8'(i) ^ 8'h5C;
      check($sformatf("fill_a%0d", i), data_out, e);
      cyc(1'b0, 1'b1, 1'b0, 8'h00, 8'(i));
      e = ~8'(i);
      check($sformatf("fill_b%0d", i), data_out, e);
    end

    // Multi-cycle reset holds data_out at 0 and wipes the filled banks.
    cyc(1'b1, 1'b0, 1'b0, 8'h00, 8'h10);
    check("rst_hold0", data_out, 8'h00);
    cyc(1'b1, 1'b1, 1'b0, 8'h00, 8'h10);
    check("rst_hold1", data_out, 8'h00);
    cyc(1'b0, 1'b1, 1'b0, 8'h00, 8'h80);
    check("post_rst_b80", data_out, 8'h00);
    // First edge after reset performs a normal write.
    cyc(1'b0, 1'b1, 1'b1, 8'hC3, 8'h80);
    cyc(1'b0, 1'b1, 1'b0, 8'h00, 8'h80);
    check("post_rst_write", data_out, 8'hC3);
    cyc(1'b0, 1'b0, 1'b0, 8'h00, 8'h80);
    check("post_rst_a80", data_out, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
